// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM state encodings
// and the serial line idle level.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port between the byte FIFO (slave) and the transmit drain (master).
interface uart_tx_fifo_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_val;

    modport master (output rd_en, input rd_data, input rd_val);
    modport slave  (input rd_en, output rd_data, output rd_val);
endinterface

// File: rtl/uart_tx_fifo_drain_baud_tick.sv
// Bit-time counter: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
// near_end flags the cycle before bit_end so callers can register end-of-bit pulses.
module uart_baud_tick #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic near_end
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign bit_end  = (cnt == CNT_W'(CLK_DIV - 1));
    assign near_end = (cnt == CNT_W'(CLK_DIV - 2));

    always_ff @(posedge clk) begin
        if (reset || clear || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pulls bytes from the FIFO read port and shifts them out as serial frames
// (start, data LSB-first, optional even parity, stop). Optional parity: UART_TX_PARITY_EN.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tx_en,
    uart_tx_fifo_drain_if.master       fifo,
    output logic                       tx,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_nxt;
    logic [IDX_W-1:0]      bit_idx;
    logic                  bit_end;
    logic                  near_end;
    logic                  last_data;
    logic                  last_stop;
`ifdef UART_TX_PARITY_EN
    logic                  par;
`endif

    // Gated by reset so no read escapes while the FSM is being held in IDLE.
    assign fifo.rd_en = !reset && (state == ST_IDLE) && tx_en;

    assign shreg_nxt = shreg >> 1;
    assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
    assign last_stop = (bit_idx == IDX_W'(STOP_BITS - 1));

    // IDLE/WAIT hold the bit timer at zero so every frame starts bit-aligned;
    // within a frame the timer wraps on bit_end, which coincides with each state entry.
    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state == ST_IDLE) || (state == ST_WAIT)),
        .bit_end  (bit_end),
        .near_end (near_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_idx    <= '0;
            tx         <= IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            frame_done <= (state == ST_STOP) && last_stop && near_end;
            case (state)
                ST_IDLE: begin
                    if (tx_en)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fifo.rd_val) begin
                        shreg   <= fifo.rd_data;
`ifdef UART_TX_PARITY_EN
                        par     <= ^fifo.rd_data;
`endif
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        tx    <= shreg[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (last_data) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par;
                            state   <= ST_PARITY;
`else
                            tx      <= IDLE_LEVEL;
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg_nxt;
                            tx      <= shreg_nxt[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        tx    <= IDLE_LEVEL;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // bit_idx is reused to count stop bits.
                    if (bit_end) begin
                        if (last_stop) begin
                            bit_idx <= '0;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= IDLE_LEVEL;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: FIFO model feeds a scoreboard of fetched bytes;
// a line monitor pops them at each start bit and checks every frame cycle.
module tb_uart_tx_fifo_drain;
    localparam int CLK_DIV   = 4;
    localparam int DW        = 8;
    localparam int STOP_BITS = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_BITS = 1 + DW + PAR + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * CLK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx_en = 1'b1;
    logic tx, busy, frame_done;

    uart_tx_fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_fifo_drain #(.CLK_DIV(CLK_DIV), .DATA_WIDTH(DW), .STOP_BITS(STOP_BITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_en      (tx_en),
        .fifo       (bus),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cyc = -100;
    int rd_cnt = 0;
    int frames_cnt = 0;
    int fd_cnt = 0;
    int last_gap = -1;
    int last_end_cyc = 0;
    bit have_end = 0;
    bit mon_in_frame = 0;
    int mon_pos = 0;
    logic [FRAME_BITS-1:0] exp_bits;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    // FIFO model: registered read, data valid the cycle after rd_en; garbage when empty.
    initial begin
        bus.rd_val  = 1'b0;
        bus.rd_data = '0;
    end
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) begin
            rd_cnt++;
            rd_cyc = cyc;
            if (fifo_q.size() > 0) begin
                logic [DW-1:0] b;
                b = fifo_q.pop_front();
                exp_q.push_back(b);
                bus.rd_data <= b;
                bus.rd_val  <= 1'b1;
            end else begin
                bus.rd_data <= DW'($urandom);
                bus.rd_val  <= 1'b0;
            end
        end else begin
            bus.rd_data <= DW'($urandom);
            bus.rd_val  <= 1'b0;
        end
        cyc++;
    end

    // Line monitor / scoreboard consumer.
    always @(negedge clk) begin
        if (reset) begin
            mon_in_frame = 0;
            have_end     = 0;
        end else begin
            if (!mon_in_frame && tx === 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_start: tx fell at cycle %0d with no fetched byte", cyc);
                end else begin
                    logic [DW-1:0] b;
                    b = exp_q.pop_front();
                    exp_bits = '1;
                    exp_bits[0] = 1'b0;
                    for (int i = 0; i < DW; i++) exp_bits[1+i] = b[i];
                    if (PAR != 0) exp_bits[1+DW] = ^b;
                    mon_in_frame = 1;
                    mon_pos = 0;
                    checks++;
                    if (cyc - rd_cyc != 2) begin
                        errors++;
                        $display("FAIL latency: start bit %0d cycles after rd_en, required 2", cyc - rd_cyc);
                    end
                    if (have_end) last_gap = cyc - last_end_cyc;
                end
            end
            if (frame_done === 1'b1) fd_cnt++;
            if (mon_in_frame) begin
                logic exp_tx;
                exp_tx = exp_bits[mon_pos / CLK_DIV];
                checks++;
                if (tx !== exp_tx || busy !== 1'b1 || frame_done !== (mon_pos == FRAME_CYC - 1)) begin
                    errors++;
                    $display("FAIL frame_cycle pos %0d: tx=%b busy=%b frame_done=%b, required tx=%b busy=1 frame_done=%b",
                             mon_pos, tx, busy, frame_done, exp_tx, (mon_pos == FRAME_CYC - 1));
                end
                mon_pos++;
                if (mon_pos == FRAME_CYC) begin
                    mon_in_frame = 0;
                    frames_cnt++;
                    last_end_cyc = cyc;
                    have_end = 1;
                end
            end else begin
                checks++;
                if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_line cycle %0d: tx=%b busy=%b frame_done=%b, required 1/0/0",
                             cyc, tx, busy, frame_done);
                end
            end
            if (busy === 1'b1 && bus.rd_en === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL read_while_busy at cycle %0d", cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (frames_cnt >= target) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: frames=%0d, required %0d", name, frames_cnt, target);
    endtask

    task automatic wait_rd(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.rd_en === 1'b1) begin
                tick(1);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_rd_timeout: no rd_en within %0d cycles", name, budget);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_en = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || bus.rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: tx=%b rd_en=%b busy=%b frame_done=%b, required 1/0/0/0",
                         tx, bus.rd_en, busy, frame_done);
            end
        end
        @(posedge clk); #1;
        tx_en = 1'b0;
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_single();
        int rd0, fd0, fr0;
        rd0 = rd_cnt; fd0 = fd_cnt; fr0 = frames_cnt;
        fifo_q.push_back(8'hA5);
        tx_en = 1'b1;
        wait_rd(10, "single");
        tx_en = 1'b0;
        wait_frames(fr0 + 1, 100, "single");
        tick(5);
        checks++;
        if (rd_cnt - rd0 != 1) begin
            errors++;
            $display("FAIL single_rd_count: %0d rd_en pulses, required 1", rd_cnt - rd0);
        end
        checks++;
        if (fd_cnt - fd0 != 1) begin
            errors++;
            $display("FAIL single_frame_done: %0d pulses, required 1", fd_cnt - fd0);
        end
    endtask

    task automatic test_empty();
        logic prev;
        tx_en = 1'b1;
        prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rd_en !== ~prev || tx !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL empty_poll cycle %0d: rd_en=%b tx=%b busy=%b, required rd_en=%b tx=1 busy=0",
                         i, bus.rd_en, tx, busy, ~prev);
            end
            prev = bus.rd_en;
        end
        tick(1);
        tx_en = 1'b0;
        tick(4);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int fr0;
        fr0 = frames_cnt;
        fifo_q.push_back(8'h07);
        fifo_q.push_back(8'h03);
        tx_en = 1'b1;
        wait_frames(fr0 + 2, 200, "parity");
        tx_en = 1'b0;
        tick(5);
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL parity_drain: fifo=%0d pending=%0d, required 0/0", fifo_q.size(), exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_mid();
        int rd0, fd0;
        bit hit;
        fifo_q.push_back(8'h5A);
        tx_en = 1'b1;
        wait_rd(10, "reset_mid");
        tx_en = 1'b0;
        hit = 0;
        // pos 18 lies inside data bit 3 (cycles 16..19 of the frame)
        for (int i = 0; i < 60 && !hit; i++) begin
            tick(1);
            if (mon_in_frame && mon_pos == 18) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_reach: data bit 3 of 0x5A not observed");
        end
        fd0 = fd_cnt;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_abort: tx=%b busy=%b frame_done=%b, required 1/0/0", tx, busy, frame_done);
        end
        tick(1);
        reset = 1'b0;
        rd0 = rd_cnt;
        tick(60);
        checks++;
        if (fd_cnt != fd0 || rd_cnt != rd0) begin
            errors++;
            $display("FAIL reset_mid_quiet: frame_done=%0d rd_en=%0d after abort, required 0/0",
                     fd_cnt - fd0, rd_cnt - rd0);
        end
        tx_en = 1'b1;
        tick(4);
        tx_en = 1'b0;
        tick(4);
        checks++;
        if (rd_cnt == rd0) begin
            errors++;
            $display("FAIL reset_mid_resume: rd_en count %0d after tx_en, required > 0", rd_cnt - rd0);
        end
    endtask

    task automatic test_back_to_back();
        int rd0, fr0;
        bit hit;
        rd0 = rd_cnt; fr0 = frames_cnt;
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        tx_en = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick(1);
            if (mon_in_frame && mon_pos == 10) hit = 1;
        end
        tx_en = 1'b0;
        wait_frames(fr0 + 1, 100, "b2b_first");
        tick(20);
        checks++;
        if (rd_cnt - rd0 != 1 || fifo_q.size() != 1) begin
            errors++;
            $display("FAIL b2b_hold: rd_en=%0d fifo=%0d, required 1/1", rd_cnt - rd0, fifo_q.size());
        end
        tx_en = 1'b1;
        wait_frames(fr0 + 2, 100, "b2b_second");
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'hC4);
        wait_frames(fr0 + 4, 200, "b2b_stream");
        tx_en = 1'b0;
        tick(5);
        checks++;
        if (last_gap != 3) begin
            errors++;
            $display("FAIL b2b_gap: start %0d cycles after last stop cycle, required 3", last_gap);
        end
        checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: fifo=%0d pending=%0d, required 0/0", fifo_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
